// File: rtl/fft_feed_pkg.sv
// fft_feed_pkg: FSM encoding, window constants and ADC-to-signed conversion for the FFT frame feeder
package fft_feed_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, FLUSH = 2'd2} state_t;
    localparam int Q15_W = 15;
    localparam logic [15:0] WIN_MAX = 16'h7FFF;
    function automatic logic [15:0] ad_to_s16(input logic [15:0] ad, input int aw, input int sh);
        logic [15:0] x;
        logic signed [15:0] s;
        x = ad ^ (16'd1 << (aw - 1));
        s = $signed(x << (16 - aw));
        s = s >>> (16 - aw);
        return s << sh;
    endfunction
endpackage

// File: rtl/fft_frame_feeder_if.sv
// fft_frame_feeder_if: AXI4-Stream link from the frame feeder to the FFT core s_axis_data port
interface fft_frame_feeder_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/fft_feed_win_rom.sv
// fft_feed_win_rom: Hann window coefficients in Q1.15 with a one-cycle registered read
module fft_feed_win_rom
    import fft_feed_pkg::*;
#(
    parameter int FRAME_LEN = 1024,
    localparam int AW = $clog2(FRAME_LEN)
) (
    input  logic          sys_clk,
    input  logic [AW-1:0] i_addr,
    output logic [15:0]   o_w
);
    function automatic logic [15:0] hann(input int n);
        real c;
        c = 0.5 * (1.0 - $cos(2.0 * 3.14159265358979 * n / FRAME_LEN));
        return 16'($rtoi($itor(WIN_MAX) * c + 0.5));
    endfunction
    logic [15:0] w_tab [FRAME_LEN];
    logic [15:0] r_w;
    for (genvar n = 0; n < FRAME_LEN; n++) begin : g_tab
        assign w_tab[n] = hann(n);
    end
    always_ff @(posedge sys_clk) r_w <= w_tab[i_addr];
    assign o_w = r_w;
endmodule

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: ADC capture, signed conversion and FIFO-buffered AXI4-Stream framing for the FFT core.
// Define FFT_FEED_WINDOW_EN to apply a Hann window in a two-stage pipeline ahead of the FIFO.
module fft_frame_feeder
    import fft_feed_pkg::*;
#(
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 16,
    parameter int AD_W       = 10,
    parameter int IN_SHIFT   = 5
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            i_arm,
    input  logic            i_cont,
    input  logic            i_stop,
    input  logic            i_sample_en,
    input  logic [AD_W-1:0] i_ad_data,
    input  logic            i_ovf_clr,
    output logic            o_busy,
    output logic            o_frame_done,
    output logic            o_ovf,
    fft_frame_feeder_if.master m_axis
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    state_t r_state, w_next;
    logic r_cont, r_stop, r_ovf, r_s_v;
    logic [CW-1:0] r_wr_cnt, r_rd_cnt;
    logic [PW:0] r_wp, r_rp;
    logic [15:0] r_mem [FIFO_DEPTH];
    logic [15:0] r_s_d, w_wd;
    logic w_wv, w_kill, w_cap, w_arm, w_empty, w_full, w_rd, w_wv_ok, w_wr, w_drop, w_wrap, w_end, w_fin;
    assign w_cap   = r_state == CAPTURE && i_sample_en;
    assign w_arm   = r_state == IDLE && i_arm;
    assign w_empty = r_wp == r_rp;
    assign w_full  = r_wp[PW-1:0] == r_rp[PW-1:0] && r_wp[PW] != r_rp[PW];
    assign w_rd    = m_axis.tvalid && m_axis.tready;
    // the write stage owns the full check so a dropped sample never advances wr_cnt
    assign w_wv_ok = w_wv && r_state == CAPTURE;
    assign w_wr    = w_wv_ok && (!w_full || w_rd);
    assign w_drop  = w_wv_ok && w_full && !w_rd;
    assign w_wrap  = w_wr && r_wr_cnt == LAST;
    assign w_end   = !r_cont || r_stop || i_stop;
    assign w_fin   = w_rd && m_axis.tlast && (r_wp - r_rp) == (PW+1)'(1);
    assign m_axis.tvalid = !w_empty;
    assign m_axis.tlast  = !w_empty && r_rd_cnt == LAST;
    assign m_axis.tdata  = {16'h0000, w_empty ? 16'h0000 : r_mem[r_rp[PW-1:0]]};
    assign o_ovf = r_ovf;
    always_ff @(posedge sys_clk) r_state <= sys_rst ? IDLE : w_next;
    always_comb begin
        w_next = (r_state == IDLE && i_arm) ? CAPTURE :
                 (r_state == CAPTURE && w_wrap && w_end) ? FLUSH :
                 (r_state == FLUSH && w_fin) ? IDLE : r_state;
    end
    always_comb begin
        o_busy       = r_state != IDLE;
        o_frame_done = w_rd && m_axis.tlast;
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cont   <= 1'b0;
            r_stop   <= 1'b0;
            r_ovf    <= 1'b0;
            r_s_v    <= 1'b0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
        end else begin
            if (w_arm) r_cont <= i_cont;
            r_stop   <= r_state != IDLE && (r_stop || i_stop);
            r_ovf    <= w_drop || (r_ovf && !i_ovf_clr);
            r_s_v    <= w_cap && !w_kill;
            r_wr_cnt <= w_arm ? '0 : w_wr ? r_wr_cnt + 1'b1 : r_wr_cnt;
            r_rd_cnt <= w_arm ? '0 : w_rd ? r_rd_cnt + 1'b1 : r_rd_cnt;
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
        end
    end
    always_ff @(posedge sys_clk) begin
        r_s_d <= ad_to_s16(16'(i_ad_data), AD_W, IN_SHIFT);
        if (w_wr) r_mem[r_wp[PW-1:0]] <= w_wd;
    end
`ifdef FFT_FEED_WINDOW_EN
    logic [CW-1:0] r_idx;
    logic [15:0] w_coef, r_p_d, r_q_d;
    logic r_p_v, r_q_v;
    logic signed [32:0] w_prod;
    fft_feed_win_rom #(.FRAME_LEN(FRAME_LEN)) u_rom (.sys_clk(sys_clk), .i_addr(r_idx), .o_w(w_coef));
    assign w_prod = $signed(r_s_d) * $signed({1'b0, w_coef});
    // a drop flushes the in-flight samples and realigns the coefficient index to wr_cnt
    assign w_kill = w_drop;
    assign w_wv   = r_q_v;
    assign w_wd   = r_q_d;
    always_ff @(posedge sys_clk) begin
        if (sys_rst || r_state != CAPTURE || w_drop) begin
            r_p_v <= 1'b0;
            r_q_v <= 1'b0;
        end else begin
            r_p_v <= r_s_v;
            r_q_v <= r_p_v;
        end
        r_p_d <= 16'(w_prod >>> Q15_W);
        r_q_d <= r_p_d;
        r_idx <= (sys_rst || w_arm) ? '0 : w_drop ? r_wr_cnt : w_cap ? r_idx + 1'b1 : r_idx;
    end
`else
    assign w_kill = 1'b0;
    assign w_wv   = r_s_v;
    assign w_wd   = r_s_d;
`endif
endmodule
